// File: rtl/pedal_i2s_rx_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pedal_i2s_rx_if                                                        |
// | Sample stream from the I2S receiver to the effects core:               |
// | FIFO head word, channel tag and valid/ready handshake.                 |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
interface pedal_i2s_rx_if #(
   parameter int SAMPLE_BITS = 16
);
   logic [SAMPLE_BITS-1:0] sample_data;
   logic                   sample_right;
   logic                   sample_valid;
   logic                   sample_ready;

   // Receiver side: drives the head word and valid, listens to ready.
   modport master (
      output sample_data,
      output sample_right,
      output sample_valid,
      input  sample_ready
   );

   // Consumer side: takes the head word when it asserts ready.
   modport slave (
      input  sample_data,
      input  sample_right,
      input  sample_valid,
      output sample_ready
   );
endinterface
`default_nettype wire

// File: rtl/pedal_i2s_rx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pedal_i2s_rx                                                           |
// | I2S audio receiver. The pad signals are oversampled in the system      |
// | clock domain. Left and right words are deserialised into a small FWFT  |
// | FIFO that the effects core reads through a valid/ready handshake.      |
// | Overflow and framing errors are reported on sticky flags.              |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module pedal_i2s_rx #(
   parameter int SAMPLE_BITS = 16,
   parameter int FIFO_DEPTH  = 4,
   parameter int LEVEL_W     = 3
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic               en,
   input  logic               i2s_bclk,
   input  logic               i2s_lrclk,
   input  logic               i2s_sdin,
   pedal_i2s_rx_if.master     smp,
   output logic [LEVEL_W-1:0] fifo_level,
   output logic               overflow,
   output logic               frame_err,
   input  logic               err_clr
);

   // Pointer width; a depth of 2 still needs a one-bit pointer.
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   // Bit counter must be able to hold SAMPLE_BITS itself.
   localparam int CNT_W = $clog2(SAMPLE_BITS + 1);

   localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(SAMPLE_BITS);
   localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
   localparam logic [PTR_W-1:0]   PTR_ONE    = PTR_W'(1);
   localparam logic [LEVEL_W-1:0] LEVEL_ONE  = LEVEL_W'(1);
   localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Pad synchronisers. bclk gets a third stage so that a rising edge can
   // be detected on stable, already-synchronised values.
   // ------------------------------------------------------------------
   logic bclk_s1_q, bclk_s2_q, bclk_s3_q;
   logic lr_s1_q, lr_s2_q;
   logic sd_s1_q, sd_s2_q;

   // Two-flop synchronisers on all pads plus the bclk edge-detect stage.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         bclk_s1_q <= 1'b0;
         bclk_s2_q <= 1'b0;
         bclk_s3_q <= 1'b0;
         lr_s1_q   <= 1'b0;
         lr_s2_q   <= 1'b0;
         sd_s1_q   <= 1'b0;
         sd_s2_q   <= 1'b0;
      end else begin
         bclk_s1_q <= i2s_bclk;
         bclk_s2_q <= bclk_s1_q;
         bclk_s3_q <= bclk_s2_q;
         lr_s1_q   <= i2s_lrclk;
         lr_s2_q   <= lr_s1_q;
         sd_s1_q   <= i2s_sdin;
         sd_s2_q   <= sd_s1_q;
      end
   end

   logic w_rise;
   logic w_boundary;
   logic lr_prev_q;

   assign w_rise     = bclk_s2_q & ~bclk_s3_q;
   // A word-select change seen at a bclk rise marks the start of a slot.
   assign w_boundary = w_rise & (lr_s2_q != lr_prev_q);

   // Remember word select from the previous rise; keeps tracking while
   // disabled so that re-enabling resynchronises on the next real boundary.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         lr_prev_q <= 1'b0;
      end else if (w_rise) begin
         lr_prev_q <= lr_s2_q;
      end
   end

   // ------------------------------------------------------------------
   // Deserialiser FSM
   // ------------------------------------------------------------------
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   chan_q, chan_d;
   logic [SAMPLE_BITS-1:0] shreg_q, shreg_d;
   logic                   push_d;
   logic                   push_q;
   logic [SAMPLE_BITS-1:0] push_word_q;
   logic                   push_right_q;
   logic                   w_ferr_set;

   // Next-state logic. The boundary rise carries the previous slot's LSB
   // (one-bit I2S delay), so it only restarts the word and is never shifted.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      chan_d     = chan_q;
      shreg_d    = shreg_q;
      push_d     = 1'b0;
      w_ferr_set = 1'b0;

      if (!en) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (w_boundary) begin
                  state_d = ST_SHIFT;
                  cnt_d   = '0;
                  chan_d  = lr_s2_q;
               end
            end

            ST_SHIFT: begin
               if (cnt_q == CNT_FULL) begin
                  // Word complete; the surplus bits of the slot are ignored.
                  push_d  = 1'b1;
                  state_d = ST_DONE;
                  if (w_boundary) begin
                     state_d = ST_SHIFT;
                     cnt_d   = '0;
                     chan_d  = lr_s2_q;
                  end
               end else if (w_boundary) begin
                  // Slot ended early: drop the partial word, start anew.
                  w_ferr_set = 1'b1;
                  cnt_d      = '0;
                  chan_d     = lr_s2_q;
               end else if (w_rise) begin
                  shreg_d = {shreg_q[SAMPLE_BITS-2:0], sd_s2_q};
                  cnt_d   = cnt_q + CNT_ONE;
               end
            end

            ST_DONE: begin
               if (w_boundary) begin
                  state_d = ST_SHIFT;
                  cnt_d   = '0;
                  chan_d  = lr_s2_q;
               end
            end

            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // FSM state register and the registered push towards the FIFO.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         chan_q       <= 1'b0;
         shreg_q      <= '0;
         push_q       <= 1'b0;
         push_word_q  <= '0;
         push_right_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         chan_q  <= chan_d;
         shreg_q <= shreg_d;
         push_q  <= push_d;
         if (push_d) begin
            push_word_q  <= shreg_q;
            push_right_q <= chan_q;
         end
      end
   end

   // ------------------------------------------------------------------
   // First-word-fall-through FIFO; each entry is {right, word}.
   // ------------------------------------------------------------------
   logic [SAMPLE_BITS:0]   mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q;
   logic [PTR_W-1:0]       rd_ptr_q;
   logic [LEVEL_W-1:0]     level_q;
   logic                   w_empty;
   logic                   w_full;
   logic                   w_do_pop;
   logic                   w_do_push;
   logic                   w_ovf_set;
   logic [SAMPLE_BITS:0]   w_head;

   assign w_empty   = (level_q == '0);
   assign w_full    = (level_q == LEVEL_FULL);
   assign w_do_pop  = en & ~w_empty & smp.sample_ready;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign w_do_push = en & push_q & (~w_full | w_do_pop);
   assign w_ovf_set = en & push_q & w_full & ~w_do_pop;

   // Storage array; contents only matter where the pointers say so.
   always_ff @(posedge wb_clk_i) begin
      if (w_do_push) begin
         mem_q[wr_ptr_q] <= {push_right_q, push_word_q};
      end
   end

   // Pointers and occupancy; disabling the receiver flushes the FIFO.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || !en) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (w_do_push) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (w_do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         if (w_do_push && !w_do_pop) begin
            level_q <= level_q + LEVEL_ONE;
         end else if (!w_do_push && w_do_pop) begin
            level_q <= level_q - LEVEL_ONE;
         end
      end
   end

   // ------------------------------------------------------------------
   // Sticky error flags; a set event wins over a simultaneous clear.
   // ------------------------------------------------------------------
   logic ovf_q;
   logic ferr_q;

   // Flag registers, held across en changes.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ovf_q  <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         ovf_q  <= w_ovf_set  | (ovf_q  & ~err_clr);
         ferr_q <= w_ferr_set | (ferr_q & ~err_clr);
      end
   end

   // Head of the FIFO is shown only when valid so that an empty FIFO reads 0.
   assign w_head           = mem_q[rd_ptr_q];
   assign smp.sample_valid = ~w_empty;
   assign smp.sample_data  = w_empty ? '0 : w_head[SAMPLE_BITS-1:0];
   assign smp.sample_right = w_empty ? 1'b0 : w_head[SAMPLE_BITS];
   assign fifo_level       = level_q;
   assign overflow         = ovf_q;
   assign frame_err        = ferr_q;

endmodule
`default_nettype wire

// File: doc/pedal_i2s_rx.md
Name: pedal_i2s_rx

Overview:
- Audio input front-end of the pedal core; sits directly upstream of the effects datapath.
- Receives I2S serial audio from the external ADC on user IO pads, all of it asynchronous to the system clock.
- Synchronises and oversamples the serial lines in the wb_clk_i domain, deserialises left and right words, and buffers them in a small first-word-fall-through FIFO.
- Presents samples to the effects core on a valid/ready handshake, with sticky overflow and framing-error flags for the register block.

Parameters:
- SAMPLE_BITS, 16, bits captured per channel word, MSB first; later bits in the slot are ignored.
- FIFO_DEPTH, 4, FIFO entries; power of two, 2..16.
- LEVEL_W, 3, width of fifo_level; equals log2(FIFO_DEPTH)+1.

Ports:
- wb_clk_i, in, 1, system clock; sole clock of the block.
- wb_rst_i, in, 1, synchronous active-high reset.
- en, in, 1, receiver enable.
- i2s_bclk, in, 1, serial bit clock from the pad; asynchronous.
- i2s_lrclk, in, 1, word select from the pad (0 = left, 1 = right); asynchronous.
- i2s_sdin, in, 1, serial data from the pad; asynchronous.
- sample_data, out, SAMPLE_BITS, FIFO head word, two's complement.
- sample_right, out, 1, channel tag of the head word (1 = right).
- sample_valid, out, 1, FIFO non-empty.
- sample_ready, in, 1, consumer accepts the head word this cycle.
- fifo_level, out, LEVEL_W, current FIFO occupancy.
- overflow, out, 1, sticky: a word was dropped because the FIFO was full.
- frame_err, out, 1, sticky: a short word was detected.
- err_clr, in, 1, clears both sticky flags.

Behaviour:
- Reset (wb_rst_i = 1 at a clock edge):
  - FSM goes to IDLE; FIFO is emptied.
  - sample_data = 0, sample_right = 0, sample_valid = 0, fifo_level = 0, overflow = 0, frame_err = 0.
  - Synchroniser flops are cleared to 0.
  - Reset mid-word discards the partial word; no flag is set.
- Input synchronisation:
  - Each of the three pad inputs passes through a 2-flop synchroniser.
  - A third register on bclk provides edge detect.
  - rise = bclk_s2 & ~bclk_s3.
  - Required bclk high time and low time: at least 4 wb_clk_i cycles each.
- Sampling: on each rise cycle, capture lr = lrclk_s2 and sd = sdin_s2. lr_prev holds lr from the previous rise.
- FSM:
  - IDLE: wait for a rise with lr != lr_prev (first boundary); then go to SHIFT with cnt = 0 and chan = lr. No error is possible in IDLE. The boundary rise carries the previous slot's LSB (I2S one-bit delay) and is not shifted in.
  - SHIFT: on each non-boundary rise, shift sd into the shift register and increment cnt. When cnt reaches SAMPLE_BITS, push {chan, word} and go to DONE.
  - DONE: ignore further bits until the next boundary rise; then set cnt = 0, chan = lr, and go to SHIFT.
  - Boundary in SHIFT with 0 <= cnt < SAMPLE_BITS: set frame_err, discard the partial word, restart SHIFT on the new channel.
  - en = 0: FSM forced to IDLE, FIFO flushed, fifo_level = 0 the next cycle. Flags are held.
- Latency:
  - The push is registered in the cycle after the rise that carries the last bit.
  - sample_valid rises in the cycle after the push.
  - Pad edge of the last bit's bclk rise to sample_valid: 5 wb_clk_i cycles.
- FIFO and handshake:
  - First-word fall-through: sample_data and sample_right are valid whenever sample_valid = 1.
  - Pop occurs when sample_valid & sample_ready. sample_ready is ignored when empty.
  - Push while full with no pop: the new word is dropped, overflow is set, and FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both take effect; the level is unchanged and no overflow.
  - Push and pop in the same cycle while at level 1: the pushed word becomes the head next cycle; sample_valid stays 1.
  - Pointers wrap modulo FIFO_DEPTH; fifo_level ranges 0..FIFO_DEPTH.
- Flags:
  - Set-dominant over err_clr: if err_clr and a set event occur in the same cycle, the flag ends at 1.
  - Otherwise err_clr = 1 clears both flags the next cycle.

Test Plan:
- Stereo frame, 32 bclk per slot, bclk period 8 clk; L = 0x8001, R = 0x7FFE -> two words popped in order (0x8001, right=0), (0x7FFE, right=1); frame_err = 0; sample_valid asserted 5 clk after the pad edge of the 16th bit's bclk rise.
- sample_ready = 0, 6 words sent (FIFO_DEPTH = 4) -> fifo_level = 4; overflow = 1 after the 5th word; the head remains word 1; draining yields words 1-4 only.
- Full FIFO with sample_ready = 1 in the exact push cycle -> fifo_level stays 4; overflow stays 0; the output order is preserved.
- lrclk toggled after 10 bits in a slot -> frame_err = 1; no push; the next full slot is received correctly; err_clr pulse -> frame_err = 0.
- wb_rst_i asserted mid-slot (bit 7) and released -> all outputs 0; no push until a new boundary and a full 16-bit word; frame_err stays 0.
- en dropped with 3 words queued -> fifo_level = 0 and sample_valid = 0 the next cycle; re-enable -> resync on the first boundary, and the first word is captured correctly.
